// File: rtl/life_run_ctrl_pkg.sv
// Shared types and constants for the Game of Life run controller.
// Grid is 8x8, row-major, bit 63 = row 0 col 0.
package life_ctrl_pkg;

  localparam int GRID_W = 64;
  localparam int RATE_W = 16;
  localparam int GEN_W  = 16;
  localparam int HR_W   = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    PAUSED = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [HR_W-1:0] HALT_NONE    = 3'b000;
  localparam logic [HR_W-1:0] HALT_LIMIT   = 3'b001;
  localparam logic [HR_W-1:0] HALT_EXTINCT = 3'b010;
  localparam logic [HR_W-1:0] HALT_STABLE  = 3'b011;
  localparam logic [HR_W-1:0] HALT_OSC2    = 3'b100;

  // Rates below 2 would let an evaluation see a grid the engine has not yet updated.
  function automatic logic [RATE_W-1:0] eff_period(input logic [RATE_W-1:0] rate_div);
    return (rate_div < RATE_W'(2)) ? RATE_W'(2) : rate_div;
  endfunction

endpackage

// File: rtl/life_run_ctrl_if.sv
// Control, engine and status signals of the Life run controller.
// master = top-level control plus engine side, slave = controller.
interface life_run_ctrl_if;
  import life_ctrl_pkg::*;

  logic              start;
  logic              stop;
  logic              single_step;
  logic              use_lfsr;
  logic [GRID_W-1:0] seed;
  logic [GRID_W-1:0] lfsr_value;
  logic [RATE_W-1:0] rate_div;
  logic [GEN_W-1:0]  max_gens;
  logic [GRID_W-1:0] grid_cur;
  logic [GRID_W-1:0] grid_next;
  logic              eng_load;
  logic [GRID_W-1:0] eng_seed;
  logic              eng_step;
  logic              busy;
  logic              done;
  logic [HR_W-1:0]   halt_reason;
  logic [GEN_W-1:0]  gen_count;

  modport master (
    output start, stop, single_step, use_lfsr, seed, lfsr_value,
    output rate_div, max_gens, grid_cur, grid_next,
    input  eng_load, eng_seed, eng_step, busy, done, halt_reason, gen_count
  );

  modport slave (
    input  start, stop, single_step, use_lfsr, seed, lfsr_value,
    input  rate_div, max_gens, grid_cur, grid_next,
    output eng_load, eng_seed, eng_step, busy, done, halt_reason, gen_count
  );

endinterface

// File: rtl/life_run_ctrl_tick_div.sv
// life_tick_div: evaluation-rate divider; ticks once every max(rate_div,2) enabled cycles.
// Counter freezes while enable is low and restarts from 0 on clear.
module life_tick_div
  import life_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [RATE_W-1:0] rate_div,
  output logic              tick
);

  logic [RATE_W-1:0] r_cnt;
  logic [RATE_W-1:0] w_last;

  assign w_last = eff_period(rate_div) - RATE_W'(1);
  // >= keeps the divider from running the full counter range if rate_div shrinks mid-run.
  assign tick   = enable && !clear && (r_cnt >= w_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= tick ? '0 : r_cnt + RATE_W'(1);
    end
  end

endmodule

// File: rtl/life_run_ctrl.sv
// life_run_ctrl: seeds the 8x8 Life engine and paces its generation steps.
// Build option LIFE_OSC2_DETECT_EN adds period-2 oscillator halting.
module life_run_ctrl
  import life_ctrl_pkg::*;
(
  input logic            clk,
  input logic            reset,
  life_run_ctrl_if.slave bus
);

  // state  | meaning
  // IDLE   | waiting for start
  // LOAD   | eng_load strobe, captured seed going into engine
  // RUN    | evaluating at the divided rate
  // PAUSED | divider frozen; single_step, resume or abort
  // HALT   | run ended, halt_reason valid, done high

  state_t            r_state;
  logic              r_eng_load;
  logic              r_eng_step;
  logic              r_busy;
  logic              r_done;
  logic [GRID_W-1:0] r_eng_seed;
  logic [GEN_W-1:0]  r_gen_count;
  logic [HR_W-1:0]   r_halt_reason;
`ifdef LIFE_OSC2_DETECT_EN
  logic [GRID_W-1:0] r_prev_grid;
`endif

  logic            w_tick;
  logic            w_div_en;
  logic            w_div_clr;
  logic            w_eval;
  logic [HR_W-1:0] w_reason;

  assign w_div_en  = (r_state == RUN);
  assign w_div_clr = (r_state == LOAD) ||
                     ((r_state == PAUSED) && bus.start && !bus.stop);

  life_tick_div u_tick_div (
    .clk      (clk),
    .reset    (reset),
    .enable   (w_div_en),
    .clear    (w_div_clr),
    .rate_div (bus.rate_div),
    .tick     (w_tick)
  );

  // stop outranks an evaluation; in PAUSED start also outranks single_step.
  assign w_eval = ((r_state == RUN) && !bus.stop && w_tick) ||
                  ((r_state == PAUSED) && !bus.stop && !bus.start && bus.single_step);

  always_comb begin
    w_reason = HALT_NONE;
    if (bus.grid_cur == '0)
      w_reason = HALT_EXTINCT;
    else if (bus.grid_next == bus.grid_cur)
      w_reason = HALT_STABLE;
`ifdef LIFE_OSC2_DETECT_EN
    else if ((r_gen_count != '0) && (bus.grid_next == r_prev_grid))
      w_reason = HALT_OSC2;
`endif
    else if ((bus.max_gens != '0) && (r_gen_count == bus.max_gens))
      w_reason = HALT_LIMIT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_eng_load    <= 1'b0;
      r_eng_step    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_eng_seed    <= '0;
      r_gen_count   <= '0;
      r_halt_reason <= HALT_NONE;
`ifdef LIFE_OSC2_DETECT_EN
      r_prev_grid   <= '0;
`endif
    end else begin
      r_eng_load <= 1'b0;
      r_eng_step <= 1'b0;

      case (r_state)
        IDLE, HALT: begin
          if (bus.start && !bus.stop) begin
            r_state       <= LOAD;
            r_eng_load    <= 1'b1;
            r_eng_seed    <= bus.use_lfsr ? bus.lfsr_value : bus.seed;
            r_gen_count   <= '0;
            r_halt_reason <= HALT_NONE;
            r_done        <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        LOAD: begin
          r_state <= RUN;
`ifdef LIFE_OSC2_DETECT_EN
          r_prev_grid <= '0;
`endif
        end
        RUN: begin
          if (bus.stop)
            r_state <= PAUSED;
        end
        PAUSED: begin
          if (bus.stop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (bus.start) begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase

      // Evaluation never coincides with a state change above, so it may override r_state.
      if (w_eval) begin
        if (w_reason != HALT_NONE) begin
          r_state       <= HALT;
          r_halt_reason <= w_reason;
          r_done        <= 1'b1;
          r_busy        <= 1'b0;
        end else begin
          r_eng_step <= 1'b1;
          if (r_gen_count != '1)
            r_gen_count <= r_gen_count + GEN_W'(1);
`ifdef LIFE_OSC2_DETECT_EN
          r_prev_grid <= bus.grid_cur;
`endif
        end
      end
    end
  end

  assign bus.eng_load    = r_eng_load;
  assign bus.eng_seed    = r_eng_seed;
  assign bus.eng_step    = r_eng_step;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.halt_reason = r_halt_reason;
  assign bus.gen_count   = r_gen_count;

endmodule

// File: tb/tb_life_run_ctrl.sv
// Directed bench for life_run_ctrl driving a behavioural 8x8 Life engine (dead borders).
`timescale 1ns/1ps
module tb_life_run_ctrl;
  import life_ctrl_pkg::*;

  localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
  localparam logic [63:0] LONE    = 64'h0000_0010_0000_0000;
  localparam logic [63:0] BLINKER = 64'h0000_0038_0000_0000;
  localparam logic [63:0] LFSR_V  = 64'hA5A5_5A5A_0F0F_F0F0;
`ifdef LIFE_OSC2_DETECT_EN
  // a blinker would halt as period-2 after one step, so long runs use a glider
  localparam logic [63:0] RUN_SEED = 64'h4020_E000_0000_0000;
`else
  localparam logic [63:0] RUN_SEED = BLINKER;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  life_run_ctrl_if bus ();

  life_run_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [63:0] life_next(input logic [63:0] g);
    logic [63:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0) && (r + dr >= 0) && (r + dr < 8) &&
                (c + dc >= 0) && (c + dc < 8))
              cnt += int'(g[63 - ((r + dr) * 8 + (c + dc))]);
          end
        end
        n[63 - (r * 8 + c)] = (cnt == 3) || (g[63 - (r * 8 + c)] && cnt == 2);
      end
    end
    return n;
  endfunction

  logic [63:0] eng_grid = '0;
  always @(posedge clk) begin
    if (bus.eng_load)
      eng_grid <= bus.eng_seed;
    else if (bus.eng_step)
      eng_grid <= life_next(eng_grid);
  end
  assign bus.grid_cur  = eng_grid;
  assign bus.grid_next = life_next(eng_grid);

  // Caller must be at a negedge; returns at the negedge after the edge that saw the pulse.
  task automatic pulse(input logic p_start, input logic p_stop, input logic p_ss);
    bus.start = p_start;
    bus.stop = p_stop;
    bus.single_step = p_ss;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.single_step = 1'b0;
  endtask

  task automatic run_until_done(input int max_cyc, output int cyc, output int steps,
                                output int bad_gaps);
    int last;
    cyc = -1; steps = 0; bad_gaps = 0; last = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (bus.eng_step) begin
        if (last >= 0 && (i - last) != 2) bad_gaps++;
        last = i;
        steps++;
      end
      if (bus.done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic configure(input logic [63:0] s, input logic [15:0] rd, input logic [15:0] mg);
    bus.seed = s;
    bus.rate_div = rd;
    bus.max_gens = mg;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus.eng_load, bus.eng_step, bus.busy, bus.done, bus.halt_reason, bus.gen_count,
         bus.eng_seed} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got load=%b step=%b busy=%b done=%b reason=%b gen=%0d seed=%h, want all 0",
               bus.eng_load, bus.eng_step, bus.busy, bus.done, bus.halt_reason, bus.gen_count, bus.eng_seed);
    end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_block_stable;
    int cyc, steps, bad;
    configure(BLOCK, 16'd4, 16'd0);
    pulse(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (bus.eng_load !== 1'b1 || bus.eng_seed !== BLOCK || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_load: got load=%b seed=%h busy=%b, want 1 %h 1", bus.eng_load, bus.eng_seed, bus.busy, BLOCK);
    end
    run_until_done(50, cyc, steps, bad);
    n_tests++;
    if (cyc !== 5) begin
      n_fail++;
      $display("FAIL t1_halt_cycle: got %0d, want 5", cyc);
    end
    n_tests++;
    if (bus.halt_reason !== HALT_STABLE || bus.gen_count !== 16'd0 || steps !== 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_stable: got reason=%b gen=%0d steps=%0d busy=%b, want 011 0 0 0",
               bus.halt_reason, bus.gen_count, steps, bus.busy);
    end
  endtask

  task automatic test_lone_extinct;
    int cyc, steps, bad;
    configure(LONE, 16'd3, 16'd0);
    pulse(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (bus.done !== 1'b0 || bus.halt_reason !== HALT_NONE || bus.gen_count !== 16'd0) begin
      n_fail++;
      $display("FAIL t2_restart_clears: got done=%b reason=%b gen=%0d, want 0 000 0",
               bus.done, bus.halt_reason, bus.gen_count);
    end
    run_until_done(60, cyc, steps, bad);
    n_tests++;
    if (bus.done !== 1'b1 || bus.halt_reason !== HALT_EXTINCT || bus.gen_count !== 16'd1 || steps !== 1) begin
      n_fail++;
      $display("FAIL t2_extinct: got done=%b reason=%b gen=%0d steps=%0d, want 1 010 1 1",
               bus.done, bus.halt_reason, bus.gen_count, steps);
    end
  endtask

  task automatic test_blinker_limit;
    int cyc, steps, bad;
    logic [2:0] exp_reason;
    int exp_gen;
`ifdef LIFE_OSC2_DETECT_EN
    exp_reason = HALT_OSC2; exp_gen = 1;
`else
    exp_reason = HALT_LIMIT; exp_gen = 5;
`endif
    configure(BLINKER, 16'd0, 16'd5);
    pulse(1'b1, 1'b0, 1'b0);
    run_until_done(100, cyc, steps, bad);
    n_tests++;
    if (bus.done !== 1'b1 || bus.halt_reason !== exp_reason || int'(bus.gen_count) !== exp_gen) begin
      n_fail++;
      $display("FAIL t3_halt: got done=%b reason=%b gen=%0d, want 1 %b %0d",
               bus.done, bus.halt_reason, bus.gen_count, exp_reason, exp_gen);
    end
    n_tests++;
    if (steps !== exp_gen || bad !== 0) begin
      n_fail++;
      $display("FAIL t3_step_pulses: got steps=%0d bad_gaps=%0d, want %0d 0", steps, bad, exp_gen);
    end
  endtask

  task automatic test_pause_single_step;
    int steps, guard;
    configure(RUN_SEED, 16'd0, 16'd0);
    pulse(1'b1, 1'b0, 1'b0);
    guard = 0;
    while (bus.gen_count !== 16'd3 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (bus.gen_count !== 16'd3) begin
      n_fail++;
      $display("FAIL t4_reach_gen3: got gen=%0d, want 3", bus.gen_count);
    end
    pulse(1'b0, 1'b1, 1'b0);
    steps = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.eng_step) steps++;
      @(negedge clk);
    end
    n_tests++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.gen_count !== 16'd3 || steps !== 0) begin
      n_fail++;
      $display("FAIL t4_paused: got busy=%b done=%b gen=%0d steps=%0d, want 1 0 3 0",
               bus.busy, bus.done, bus.gen_count, steps);
    end
    pulse(1'b0, 1'b0, 1'b1);
    steps = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.eng_step) steps++;
      @(negedge clk);
    end
    n_tests++;
    if (steps !== 1 || bus.gen_count !== 16'd4 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL t4_single_step: got steps=%0d gen=%0d busy=%b, want 1 4 1", steps, bus.gen_count, bus.busy);
    end
    pulse(1'b1, 1'b0, 1'b0);
    guard = 0;
    while (bus.eng_step !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (bus.eng_step !== 1'b1 || bus.gen_count !== 16'd5) begin
      n_fail++;
      $display("FAIL t4_resume: got step=%b gen=%0d, want 1 5", bus.eng_step, bus.gen_count);
    end
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    steps = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.eng_step || bus.eng_load) steps++;
      @(negedge clk);
    end
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.gen_count !== 16'd5 || steps !== 0) begin
      n_fail++;
      $display("FAIL t4_abort_idle: got busy=%b done=%b gen=%0d strobes=%0d, want 0 0 5 0",
               bus.busy, bus.done, bus.gen_count, steps);
    end
  endtask

  task automatic test_lfsr_seed;
    configure(BLOCK, 16'd100, 16'd0);
    bus.use_lfsr = 1'b1;
    bus.lfsr_value = LFSR_V;
    pulse(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (bus.eng_load !== 1'b1 || bus.eng_seed !== LFSR_V) begin
      n_fail++;
      $display("FAIL t5_lfsr_load: got load=%b seed=%h, want 1 %h", bus.eng_load, bus.eng_seed, LFSR_V);
    end
    @(negedge clk);
    n_tests++;
    if (bus.eng_load !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_load_width: got load=%b in second cycle, want 0", bus.eng_load);
    end
    bus.use_lfsr = 1'b0;
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_abort: got busy=%b, want 0", bus.busy);
    end
  endtask

  task automatic test_async_reset;
    int steps;
    configure(RUN_SEED, 16'd0, 16'd0);
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b1 || bus.gen_count === 16'd0) begin
      n_fail++;
      $display("FAIL t6_running: got busy=%b gen=%0d, want busy 1 and gen nonzero", bus.busy, bus.gen_count);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({bus.eng_load, bus.eng_step, bus.busy, bus.done, bus.halt_reason, bus.gen_count,
         bus.eng_seed} !== '0) begin
      n_fail++;
      $display("FAIL t6_async_reset: got load=%b step=%b busy=%b done=%b reason=%b gen=%0d seed=%h, want all 0",
               bus.eng_load, bus.eng_step, bus.busy, bus.done, bus.halt_reason, bus.gen_count, bus.eng_seed);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.eng_load !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_idle_after: got busy=%b load=%b, want 0 0", bus.busy, bus.eng_load);
    end
    pulse(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (bus.eng_load !== 1'b1 || bus.eng_seed !== RUN_SEED) begin
      n_fail++;
      $display("FAIL t6_reload: got load=%b seed=%h, want 1 %h", bus.eng_load, bus.eng_seed, RUN_SEED);
    end
    steps = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.eng_step) steps++;
    end
    n_tests++;
    if (bus.gen_count !== 16'd4 || steps !== 4) begin
      n_fail++;
      $display("FAIL t6_restep: got gen=%0d steps=%0d, want 4 4", bus.gen_count, steps);
    end
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.single_step = 1'b0;
    bus.use_lfsr = 1'b0;
    bus.seed = '0;
    bus.lfsr_value = '0;
    bus.rate_div = '0;
    bus.max_gens = '0;
    test_reset();
    test_block_stable();
    test_lone_extinct();
    test_blinker_limit();
    test_pause_single_step();
    test_lfsr_seed();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
